// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_pkg
// Purpose  : Shared LFSR/PRBS definitions: checker states, maximal tap masks.
// Revision : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

   typedef enum logic [0:0] {
      SEARCH = 1'b0,
      LOCKED = 1'b1
   } chk_state_t;

   localparam int DEFAULT_LENGTH = 16;

   // Masks read left to right as r[0] (newest) .. r[LENGTH-1] (oldest)
   localparam logic [6:0]  TAPS_7  = 7'b0000011;
   localparam logic [14:0] TAPS_15 = {13'd0, 2'b11};
   localparam logic [15:0] TAPS_16 = 16'b0110100000000001;
   localparam logic [22:0] TAPS_23 = {5'b00001, 17'd0, 1'b1};
   localparam logic [30:0] TAPS_31 = {3'b001, 27'd0, 1'b1};

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Up counter that sticks at all-ones, with synchronous clear.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= '0;
      end else if (inc && (r_count != '1)) begin
         r_count <= r_count + W'(1);
      end
   end

   assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/prbs_checker.sv
`default_nettype none
// ============================================================================
// Module   : prbs_checker
// Purpose  : Self-synchronising serial PRBS checker with flywheel lock,
//            windowed loss-of-lock and saturating error/bit statistics.
//            Optional macro PRBS_CHK_INVERT_EN adds an 'invert' input.
// Revision : 1.0 - initial release
// ============================================================================
module prbs_checker
   import lfsr_pkg::*;
#(
   parameter int                LENGTH     = DEFAULT_LENGTH,
   parameter logic [LENGTH-1:0] TAPS       = TAPS_16,
   parameter int                LOCK_COUNT = 32,
   parameter int                WINDOW     = 64,
   parameter int                ERR_THRESH = 8,
   parameter int                CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             din,
`ifdef PRBS_CHK_INVERT_EN
   input  logic             invert,
`endif
   input  logic             clear,
   output logic             locked,
   output logic             err,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] bit_count
);

   localparam int c_fill_w  = $clog2(LENGTH + 1);
   localparam int c_match_w = $clog2(LOCK_COUNT + 1);
   localparam int c_win_w   = $clog2(WINDOW + 1);
   localparam int c_werr_w  = $clog2(ERR_THRESH + 1);

   localparam logic [c_fill_w-1:0]  c_fill_full  = c_fill_w'(LENGTH);
   localparam logic [c_match_w-1:0] c_match_last = c_match_w'(LOCK_COUNT - 1);
   localparam logic [c_win_w-1:0]   c_win_last   = c_win_w'(WINDOW - 1);
   localparam logic [c_werr_w-1:0]  c_werr_last  = c_werr_w'(ERR_THRESH - 1);

   logic                 w_din;
   logic                 w_pred;
   logic                 w_miss;
   chk_state_t           r_state,  w_state_nx;
   logic [LENGTH-1:0]    r_sr,     w_sr_nx;
   logic [c_fill_w-1:0]  r_fill,   w_fill_nx;
   logic [c_match_w-1:0] r_match,  w_match_nx;
   logic [c_win_w-1:0]   r_win,    w_win_nx;
   logic [c_werr_w-1:0]  r_werr,   w_werr_nx;
   logic                 r_err,    w_err_nx;
   logic                 w_check;

`ifdef PRBS_CHK_INVERT_EN
   assign w_din = din ^ invert;
`else
   assign w_din = din;
`endif

   // Vector MSB holds the newest bit, so TAPS aligns position-for-position.
   assign w_pred = ^(TAPS & r_sr);
   assign w_miss = (w_din != w_pred);

   always_comb begin
      w_state_nx = r_state;
      w_sr_nx    = r_sr;
      w_fill_nx  = r_fill;
      w_match_nx = r_match;
      w_win_nx   = r_win;
      w_werr_nx  = r_werr;
      w_err_nx   = 1'b0;
      w_check    = 1'b0;
      if (enable) begin
         case (r_state)
            SEARCH: begin
               w_sr_nx = {w_din, r_sr[LENGTH-1:1]};
               if (r_fill != c_fill_full) begin
                  w_fill_nx = r_fill + c_fill_w'(1);
               end else if (!w_miss && (r_sr != '0)) begin
                  if (r_match == c_match_last) begin
                     w_state_nx = LOCKED;
                     w_match_nx = '0;
                     w_win_nx   = '0;
                     w_werr_nx  = '0;
                  end else begin
                     w_match_nx = r_match + c_match_w'(1);
                  end
               end else begin
                  w_match_nx = '0;
               end
            end
            LOCKED: begin
               w_sr_nx  = {w_pred, r_sr[LENGTH-1:1]};
               w_check  = 1'b1;
               w_err_nx = w_miss;
               // Threshold wins over a coincident window wrap.
               if (w_miss && (r_werr == c_werr_last)) begin
                  w_state_nx = SEARCH;
                  w_fill_nx  = '0;
                  w_match_nx = '0;
                  w_win_nx   = '0;
                  w_werr_nx  = '0;
               end else if (r_win == c_win_last) begin
                  w_win_nx  = '0;
                  w_werr_nx = '0;
               end else begin
                  w_win_nx  = r_win + c_win_w'(1);
                  w_werr_nx = r_werr + c_werr_w'(w_miss);
               end
            end
            default: w_state_nx = SEARCH;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= SEARCH;
         r_sr    <= '0;
         r_fill  <= '0;
         r_match <= '0;
         r_win   <= '0;
         r_werr  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_sr    <= w_sr_nx;
         r_fill  <= w_fill_nx;
         r_match <= w_match_nx;
         r_win   <= w_win_nx;
         r_werr  <= w_werr_nx;
         r_err   <= w_err_nx;
      end
   end

   assign locked = (r_state == LOCKED);
   assign err    = r_err;

   sat_counter #(.W(CNT_W)) u_err_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_err_nx),
      .clr   (clear),
      .count (err_count)
   );

   sat_counter #(.W(CNT_W)) u_bit_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_check),
      .clr   (clear),
      .count (bit_count)
   );

endmodule
`default_nettype wire

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Serial PRBS checker; the receive-side counterpart of the team's Fibonacci LFSR pattern generator.
- Self-synchronises to an incoming pseudo-random bit stream and declares lock after a run of correct predictions.
- Once locked, free-runs its own LFSR (flywheel), flags each bit error and keeps saturating error/bit statistics.
- Used in link BIST and loopback test paths.

Parameters:
LENGTH, 16, LFSR length; register r[0:LENGTH-1], r[0] = newest bit
TAPS, 16'b0110100000000001, tap mask; predicted bit p = ^(TAPS & r)
LOCK_COUNT, 32, consecutive correct predictions required to lock (>=1)
WINDOW, 64, observation window in checked bits for loss-of-lock
ERR_THRESH, 8, errors within one WINDOW that force loss of lock (1..WINDOW)
CNT_W, 32, width of statistics counters

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
enable  input  1  din valid this cycle
din  input  1  received serial bit
clear  input  1  synchronous clear of err_count/bit_count
locked  output  1  checker in LOCKED state
err  output  1  one-cycle pulse: mismatch on a checked bit while LOCKED
err_count  output  CNT_W  saturating error count
bit_count  output  CNT_W  saturating count of bits checked while LOCKED

Behaviour:
- Reset (rst=0, async): state SEARCH; r, fill, match, window and error counters = 0; locked=0, err=0, err_count=0, bit_count=0.
- All state advances only on cycles with enable=1. With enable=0: nothing changes and err=0.
- Outputs are registered. locked, err and the counters reflect a bit one cycle after that bit is sampled.
- SEARCH:
  - r <= {din, r[0:LENGTH-2]} (self-seeding from the stream).
  - fill counts up to LENGTH. Comparisons are enabled only once fill==LENGTH.
  - When enabled: din==p and r!=0 -> match++; otherwise match=0. The all-zero register never counts, which prevents false lock on an idle stream.
  - match reaching LOCK_COUNT -> LOCKED. Clear window and window-error counters.
- LOCKED:
  - r <= {p, r[0:LENGTH-2]} (flywheel), so a single line error produces exactly one err pulse.
  - Every checked bit: bit_count++, saturating at all-ones.
  - din!=p: err=1, err_count++ (saturating), werr++.
  - Window counter increments each checked bit. On reaching WINDOW, window counter and werr reset to 0.
  - werr reaching ERR_THRESH -> SEARCH, with fill=0 and match=0. Register r is kept but refilled. The threshold takes priority when it coincides with the window wrap.
- clear:
  - Zeroes err_count and bit_count only. No effect on state, r or the window.
  - clear in the same cycle as an error: counter reads 0, err still pulses.
- Timing: with a continuous clean stream, locked rises the cycle after bit LENGTH+LOCK_COUNT (48 with defaults).
- Reset mid-operation: immediate return to reset values; a full reacquire is required.

Optional Feature:
- Macro PRBS_CHK_INVERT_EN.
- Defined: adds input port invert (1 bit, quasi-static). When invert=1, din is complemented before all processing, which handles polarity-swapped lanes.
- Undefined: no invert port; din is used as-is.

Decomposition:
- Shared package lfsr_pkg:
  - enum typedef for checker state {SEARCH, LOCKED}
  - default TAPS constants for 7/15/16/23/31-bit maximal polynomials
  - default LENGTH
- One sub-module, sat_counter (parameter W; inputs inc, clr; saturating output), instantiated for err_count and bit_count.

Test Plan:
- Continuous default PRBS16 from generator seed 16'hACE1, enable=1 -> locked=1 the cycle after bit 48; err_count=0; bit_count=100 after 100 further bits.
- Locked, flip one bit at stream index 200 -> exactly one err pulse; err_count=1; locked stays 1; no further errors.
- Locked, invert 8 bits spread within 64 bits -> locked=0 the cycle after the 8th error; err_count=8. Clean stream afterwards -> relock after 48 more bits.
- 500 bits of all-zero din -> locked never asserts; err never asserts.
- clear=1 in the same cycle as an injected error -> err pulses; err_count=0 and bit_count=0 next cycle; locked unchanged.
- Enable toggled 50% duty with the stream of the first test -> lock after 48 valid bits. Also assert rst=0 mid-lock -> locked, counters and err drop to 0 asynchronously.
